// File: rtl/cpu_types_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : cpu_types_pkg
//  Description : Shared CPU types for the instruction cache: the 32-bit word
//                type, the cache controller state encoding, the byte-offset
//                width of a word address, and a width helper for index fields.
//  Revision    : 1.0 - initial release
// ============================================================================
package cpu_types_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        FILL = 1'b1
    } icache_state_t;

    // Number of byte-offset bits below a 32-bit word address.
    localparam int ICACHE_WORD_OFF = 2;

    // Width of an index selecting one of n items; never less than one bit so
    // degenerate configurations (n == 1) still produce legal vectors.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/assoc_icache_if.sv
`default_nettype none
// ============================================================================
//  Module      : assoc_icache_if
//  Description : Datapath and memory signals of the instruction cache.
//                slave  : cache side (consumes requests, issues memory reads)
//                master : environment side (datapath + instruction memory)
//  Signals     : imemREN/imemaddr/ihit/imemload - datapath fetch port
//                iflush                         - invalidate all lines
//                iREN/iaddr/iwait/iload         - memory read port
//  Revision    : 1.0 - initial release
// ============================================================================
interface assoc_icache_if;
    import cpu_types_pkg::*;

    logic  imemREN;
    word_t imemaddr;
    logic  ihit;
    word_t imemload;
    logic  iflush;
    logic  iREN;
    word_t iaddr;
    logic  iwait;
    word_t iload;

    modport slave (
        input  imemREN, imemaddr, iflush, iwait, iload,
        output ihit, imemload, iREN, iaddr
    );

    modport master (
        output imemREN, imemaddr, iflush, iwait, iload,
        input  ihit, imemload, iREN, iaddr
    );

endinterface
`default_nettype wire

// File: rtl/icache_tag_array.sv
`default_nettype none
// ============================================================================
//  Module      : icache_tag_array
//  Description : Tag, valid, data and FIFO replacement-pointer storage of a
//                set-associative instruction cache. Lookup and victim choice
//                are combinational; writes happen on the rising clock edge.
//  Ports       : CLK, RST          - clock, synchronous active-high reset
//                flush             - clear all valid bits and pointers
//                rd_index/tag/off  - lookup address fields
//                rd_hit, rd_data   - lookup result
//                victim_way        - way to fill on a miss in rd_index
//                wr_en/index/way/off/data - store one fill word
//                fill_done, fill_tag      - validate line, advance pointer
//  Revision    : 1.0 - initial release
// ============================================================================
module icache_tag_array
    import cpu_types_pkg::*;
#(
    parameter  int SETS     = 16,
    parameter  int WAYS     = 2,
    parameter  int BLKWORDS = 2,
    localparam int IW       = idx_w(SETS),
    localparam int WW       = idx_w(WAYS),
    localparam int CW       = idx_w(BLKWORDS),
    localparam int TW       = 32 - $clog2(SETS) - $clog2(BLKWORDS) - ICACHE_WORD_OFF
) (
    input  wire logic          CLK,
    input  wire logic          RST,
    input  wire logic          flush,
    input  wire logic [IW-1:0] rd_index,
    input  wire logic [TW-1:0] rd_tag,
    input  wire logic [CW-1:0] rd_off,
    output logic               rd_hit,
    output word_t              rd_data,
    output logic [WW-1:0]      victim_way,
    input  wire logic          wr_en,
    input  wire logic [IW-1:0] wr_index,
    input  wire logic [WW-1:0] wr_way,
    input  wire logic [CW-1:0] wr_off,
    input  wire word_t         wr_data,
    input  wire logic          fill_done,
    input  wire logic [TW-1:0] fill_tag
);

    logic          valid_q [SETS][WAYS];
    logic [WW-1:0] ptr_q   [SETS];
    logic [TW-1:0] tag_mem [SETS][WAYS];
    word_t         data_mem[SETS][WAYS][BLKWORDS];

    logic [WW-1:0] w_hit_way;

    // Valid bits and replacement pointers are the only reset state.
    always_ff @(posedge CLK) begin
        if (RST || flush) begin
            for (int s = 0; s < SETS; s++) begin
                ptr_q[s] <= '0;
                for (int w = 0; w < WAYS; w++) begin
                    valid_q[s][w] <= 1'b0;
                end
            end
        end else if (fill_done) begin
            valid_q[wr_index][wr_way] <= 1'b1;
            // The pointer advances on every completed fill, so it tracks
            // insertion order even while the set still has invalid ways.
            ptr_q[wr_index] <= (WAYS == 1) ? '0 : WW'(ptr_q[wr_index] + 1'b1);
        end
    end

    always_ff @(posedge CLK) begin
        if (wr_en) begin
            data_mem[wr_index][wr_way][wr_off] <= wr_data;
        end
        if (fill_done) begin
            tag_mem[wr_index][wr_way] <= fill_tag;
        end
    end

    always_comb begin
        rd_hit    = 1'b0;
        w_hit_way = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (valid_q[rd_index][w] && (tag_mem[rd_index][w] == rd_tag)) begin
                rd_hit    = 1'b1;
                w_hit_way = WW'(w);
            end
        end
        rd_data = data_mem[rd_index][w_hit_way][rd_off];
    end

    // Scanning downwards leaves the lowest-index invalid way selected; the
    // FIFO pointer is used only when every way is valid.
    always_comb begin
        victim_way = ptr_q[rd_index];
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (!valid_q[rd_index][w]) begin
                victim_way = WW'(w);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/assoc_icache.sv
`default_nettype none
// ============================================================================
//  Module      : assoc_icache
//  Description : Set-associative, read-only instruction cache with a two-state
//                (IDLE/FILL) controller. Hits return data combinationally;
//                misses fetch the whole block word by word from memory.
//  Ports       : CLK, RST   - clock, synchronous active-high reset
//                bus        - assoc_icache_if.slave (fetch + memory ports)
//                hit_count  - hit cycles   (only with ICACHE_STATS_EN)
//                miss_count - started fills (only with ICACHE_STATS_EN)
//  Options     : ICACHE_STATS_EN - adds the hit/miss statistics counters
//  Revision    : 1.0 - initial release
// ============================================================================
module assoc_icache
    import cpu_types_pkg::*;
#(
    parameter int SETS     = 16,
    parameter int WAYS     = 2,
    parameter int BLKWORDS = 2
) (
    input  wire logic        CLK,
    input  wire logic        RST,
`ifdef ICACHE_STATS_EN
    output word_t            hit_count,
    output word_t            miss_count,
`endif
    assoc_icache_if.slave    bus
);

    localparam int    IW       = idx_w(SETS);
    localparam int    WW       = idx_w(WAYS);
    localparam int    CW       = idx_w(BLKWORDS);
    localparam int    IDX_LSB  = $clog2(BLKWORDS) + ICACHE_WORD_OFF;
    localparam int    TAG_LSB  = IDX_LSB + $clog2(SETS);
    localparam int    TW       = 32 - TAG_LSB;
    localparam word_t BLK_MASK = ~word_t'(BLKWORDS * 4 - 1);

    icache_state_t state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    word_t         base_q, base_d;
    logic [WW-1:0] way_q, way_d;

    logic [IW-1:0] w_rd_index;
    logic [TW-1:0] w_rd_tag;
    logic [CW-1:0] w_rd_off;
    logic          w_rd_hit;
    word_t         w_rd_data;
    logic [WW-1:0] w_victim;
    logic          w_wr_en;
    logic          w_fill_done;
    logic          w_start_fill;
    logic          w_ihit;

    assign w_rd_index = IW'(bus.imemaddr >> IDX_LSB);
    assign w_rd_tag   = TW'(bus.imemaddr >> TAG_LSB);
    assign w_rd_off   = (BLKWORDS > 1) ? CW'(bus.imemaddr >> ICACHE_WORD_OFF) : '0;

    icache_tag_array #(
        .SETS     (SETS),
        .WAYS     (WAYS),
        .BLKWORDS (BLKWORDS)
    ) u_tag_array (
        .CLK        (CLK),
        .RST        (RST),
        .flush      (bus.iflush),
        .rd_index   (w_rd_index),
        .rd_tag     (w_rd_tag),
        .rd_off     (w_rd_off),
        .rd_hit     (w_rd_hit),
        .rd_data    (w_rd_data),
        .victim_way (w_victim),
        .wr_en      (w_wr_en),
        .wr_index   (IW'(base_q >> IDX_LSB)),
        .wr_way     (way_q),
        .wr_off     (cnt_q),
        .wr_data    (bus.iload),
        .fill_done  (w_fill_done),
        .fill_tag   (TW'(base_q >> TAG_LSB))
    );

    // A hit is only reported while idle; flush and reset both suppress it.
    assign w_ihit       = (state_q == IDLE) && bus.imemREN && !bus.iflush && !RST && w_rd_hit;
    assign bus.ihit     = w_ihit;
    assign bus.imemload = w_ihit ? w_rd_data : '0;

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        base_d       = base_q;
        way_d        = way_q;
        w_wr_en      = 1'b0;
        w_fill_done  = 1'b0;
        w_start_fill = 1'b0;
        bus.iREN     = 1'b0;
        bus.iaddr    = '0;

        case (state_q)
            IDLE: begin
                if (!bus.iflush && bus.imemREN && !w_rd_hit) begin
                    state_d      = FILL;
                    cnt_d        = '0;
                    base_d       = bus.imemaddr & BLK_MASK;
                    way_d        = w_victim;
                    w_start_fill = !RST;
                end
            end
            FILL: begin
                bus.iREN  = 1'b1;
                bus.iaddr = base_q + (word_t'(cnt_q) << ICACHE_WORD_OFF);
                if (bus.iflush) begin
                    // Abort: the partial line is never validated.
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (!bus.iwait) begin
                    w_wr_en = !RST;
                    if (cnt_q == CW'(BLKWORDS - 1)) begin
                        w_fill_done = !RST;
                        state_d     = IDLE;
                        cnt_d       = '0;
                    end else begin
                        cnt_d = CW'(cnt_q + 1'b1);
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (RST) begin
            bus.iREN  = 1'b0;
            bus.iaddr = '0;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            base_q  <= '0;
            way_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            base_q  <= base_d;
            way_q   <= way_d;
        end
    end

`ifdef ICACHE_STATS_EN
    word_t hit_count_q, hit_count_d;
    word_t miss_count_q, miss_count_d;

    always_comb begin
        hit_count_d  = hit_count_q  + (w_ihit       ? 32'd1 : 32'd0);
        miss_count_d = miss_count_q + (w_start_fill ? 32'd1 : 32'd0);
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            hit_count_q  <= '0;
            miss_count_q <= '0;
        end else begin
            hit_count_q  <= hit_count_d;
            miss_count_q <= miss_count_d;
        end
    end

    assign hit_count  = hit_count_q;
    assign miss_count = miss_count_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_assoc_icache.sv
`default_nettype none
// ============================================================================
//  Module      : tb_assoc_icache
//  Description : Directed self-checking bench for assoc_icache. dut1 uses the
//                default geometry; dut2 uses SETS=4, WAYS=1, BLKWORDS=4.
//                Memory returns 0xC0DE0000 | addr[15:0] for every word.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_assoc_icache;
    import cpu_types_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;
    logic rst2;
    logic iwait_v;
    int   cur;
    int   vectors     = 0;
    int   miscompares = 0;

    assoc_icache_if bus1();
    assoc_icache_if bus2();

`ifdef ICACHE_STATS_EN
    word_t hc1, mc1, hc2, mc2;
`endif

    assoc_icache #(.SETS(16), .WAYS(2), .BLKWORDS(2)) dut (
        .CLK        (clk),
        .RST        (rst),
`ifdef ICACHE_STATS_EN
        .hit_count  (hc1),
        .miss_count (mc1),
`endif
        .bus        (bus1)
    );

    assoc_icache #(.SETS(4), .WAYS(1), .BLKWORDS(4)) dut2 (
        .CLK        (clk),
        .RST        (rst2),
`ifdef ICACHE_STATS_EN
        .hit_count  (hc2),
        .miss_count (mc2),
`endif
        .bus        (bus2)
    );

    function automatic word_t mem_f(input word_t a);
        return 32'hC0DE_0000 | {16'h0000, a[15:0]};
    endfunction

    assign bus1.iload = mem_f(bus1.iaddr);
    assign bus2.iload = mem_f(bus2.iaddr);
    assign bus1.iwait = iwait_v;
    assign bus2.iwait = iwait_v;

    // Outputs of whichever DUT the current scenario targets.
    logic  o_ihit, o_iren;
    word_t o_iaddr, o_load;
    always_comb begin
        if (cur == 1) begin
            o_ihit  = bus2.ihit;
            o_iren  = bus2.iREN;
            o_iaddr = bus2.iaddr;
            o_load  = bus2.imemload;
        end else begin
            o_ihit  = bus1.ihit;
            o_iren  = bus1.iREN;
            o_iaddr = bus1.iaddr;
            o_load  = bus1.imemload;
        end
    end

    // Results of the last run_read.
    int    r_hit_cyc;
    word_t r_data;
    int    r_n;
    word_t r_addr [8];
    logic  r_iren0;
    word_t r_iaddr0;
    int    r_unstable;

    task automatic drive_req(input int sel, input logic ren, input word_t addr, input logic fl);
        if (sel == 1) begin
            bus2.imemREN = ren; bus2.imemaddr = addr; bus2.iflush = fl;
        end else begin
            bus1.imemREN = ren; bus1.imemaddr = addr; bus1.iflush = fl;
        end
    endtask

    // Issue one fetch and hold it until ihit (bounded). Memory stalls each
    // word for stall_n cycles. Records hit cycle, data and accepted iaddrs.
    task automatic run_read(input int sel, input word_t addr, input int stall_n);
        int    stall;
        logic  prev_stalled;
        word_t prev;
        cur = sel;
        r_hit_cyc = -1; r_n = 0; r_unstable = 0; r_data = '0;
        stall = 0; prev_stalled = 1'b0; prev = '0;
        @(negedge clk);
        drive_req(sel, 1'b1, addr, 1'b0);
        for (int c = 0; c < 60; c++) begin
            if (o_iren) begin
                if (stall < stall_n) begin iwait_v = 1'b1; stall++; end
                else begin iwait_v = 1'b0; stall = 0; end
            end else begin
                iwait_v = 1'b0;
            end
            #1;
            if (c == 0) begin r_iren0 = o_iren; r_iaddr0 = o_iaddr; end
            if (prev_stalled && o_iren && (o_iaddr !== prev)) r_unstable++;
            prev_stalled = o_iren && iwait_v;
            prev = o_iaddr;
            if (o_ihit) begin
                if (o_iren) r_unstable++;
                r_hit_cyc = c;
                r_data    = o_load;
                break;
            end
            if (o_iren && !iwait_v && r_n < 8) begin
                r_addr[r_n] = o_iaddr;
                r_n++;
            end
            @(negedge clk);
        end
        @(negedge clk);
        drive_req(sel, 1'b0, addr, 1'b0);
        iwait_v = 1'b0;
    endtask

    task automatic test_reset;
        cur = 0;
        @(negedge clk);
        rst = 1'b1; drive_req(0, 1'b1, 32'h100, 1'b1);
        repeat (2) @(negedge clk);
        #1;
        vectors++;
        if ({o_ihit, o_iren} !== 2'b00 || o_iaddr !== 32'h0 || o_load !== 32'h0) begin
            miscompares++;
            $display("FAIL reset_during: ihit=%b iREN=%b iaddr=%h imemload=%h, want all 0", o_ihit, o_iren, o_iaddr, o_load);
        end
        @(negedge clk);
        rst = 1'b0; rst2 = 1'b0; drive_req(0, 1'b0, 32'h100, 1'b0);
        #1;
        vectors++;
        if ({o_ihit, o_iren} !== 2'b00 || o_iaddr !== 32'h0 || o_load !== 32'h0) begin
            miscompares++;
            $display("FAIL reset_after: ihit=%b iREN=%b iaddr=%h imemload=%h, want all 0", o_ihit, o_iren, o_iaddr, o_load);
        end
`ifdef ICACHE_STATS_EN
        vectors++;
        if (hc1 !== 32'd0 || mc1 !== 32'd0) begin
            miscompares++;
            $display("FAIL reset_counters: hit=%0d miss=%0d, want 0 0", hc1, mc1);
        end
`endif
    endtask

    task automatic test_cold_miss;
        run_read(0, 32'h100, 0);
        vectors++;
        if (r_iren0 !== 1'b0 || r_iaddr0 !== 32'h0) begin
            miscompares++;
            $display("FAIL cold_idle_mem: iREN=%b iaddr=%h, want 0 0", r_iren0, r_iaddr0);
        end
        vectors++;
        if (r_hit_cyc !== 3) begin
            miscompares++;
            $display("FAIL cold_hit_cycle: got %0d, want 3", r_hit_cyc);
        end
        vectors++;
        if (r_n !== 2 || r_addr[0] !== 32'h100 || r_addr[1] !== 32'h104) begin
            miscompares++;
            $display("FAIL cold_fill_addrs: n=%0d a0=%h a1=%h, want 2 100 104", r_n, r_addr[0], r_addr[1]);
        end
        vectors++;
        if (r_data !== 32'hC0DE0100) begin
            miscompares++;
            $display("FAIL cold_data: got %h, want c0de0100", r_data);
        end
`ifdef ICACHE_STATS_EN
        vectors++;
        if (mc1 !== 32'd1 || hc1 !== 32'd1) begin
            miscompares++;
            $display("FAIL cold_counters: hit=%0d miss=%0d, want 1 1", hc1, mc1);
        end
`endif
    endtask

    task automatic test_idle_quiet;
        cur = 0;
        @(negedge clk);
        drive_req(0, 1'b0, 32'h104, 1'b0);
        #1;
        vectors++;
        if ({o_ihit, o_iren} !== 2'b00 || o_iaddr !== 32'h0 || o_load !== 32'h0) begin
            miscompares++;
            $display("FAIL idle_quiet: ihit=%b iREN=%b iaddr=%h imemload=%h, want all 0", o_ihit, o_iren, o_iaddr, o_load);
        end
    endtask

    task automatic test_hit;
        run_read(0, 32'h104, 0);
        vectors++;
        if (r_hit_cyc !== 0 || r_n !== 0 || r_unstable !== 0) begin
            miscompares++;
            $display("FAIL hit_same_cycle: cyc=%0d fills=%0d bad=%0d, want 0 0 0", r_hit_cyc, r_n, r_unstable);
        end
        vectors++;
        if (r_data !== 32'hC0DE0104) begin
            miscompares++;
            $display("FAIL hit_data: got %h, want c0de0104", r_data);
        end
`ifdef ICACHE_STATS_EN
        vectors++;
        if (hc1 !== 32'd2 || mc1 !== 32'd1) begin
            miscompares++;
            $display("FAIL hit_counters: hit=%0d miss=%0d, want 2 1", hc1, mc1);
        end
`endif
    endtask

    task automatic test_eviction;
        run_read(0, 32'h180, 0);
        vectors++;
        if (r_hit_cyc !== 3 || r_addr[0] !== 32'h180) begin
            miscompares++;
            $display("FAIL evict_180_fill: cyc=%0d a0=%h, want 3 180", r_hit_cyc, r_addr[0]);
        end
        run_read(0, 32'h200, 0);
        vectors++;
        if (r_hit_cyc !== 3 || r_data !== 32'hC0DE0200) begin
            miscompares++;
            $display("FAIL evict_200_fill: cyc=%0d data=%h, want 3 c0de0200", r_hit_cyc, r_data);
        end
        run_read(0, 32'h184, 0);
        vectors++;
        if (r_hit_cyc !== 0 || r_data !== 32'hC0DE0184) begin
            miscompares++;
            $display("FAIL evict_180_kept: cyc=%0d data=%h, want 0 c0de0184", r_hit_cyc, r_data);
        end
        run_read(0, 32'h100, 0);
        vectors++;
        if (r_hit_cyc !== 3 || r_addr[0] !== 32'h100 || r_data !== 32'hC0DE0100) begin
            miscompares++;
            $display("FAIL evict_100_gone: cyc=%0d a0=%h data=%h, want 3 100 c0de0100", r_hit_cyc, r_addr[0], r_data);
        end
`ifdef ICACHE_STATS_EN
        vectors++;
        if (hc1 !== 32'd6 || mc1 !== 32'd4) begin
            miscompares++;
            $display("FAIL evict_counters: hit=%0d miss=%0d, want 6 4", hc1, mc1);
        end
`endif
    endtask

    task automatic test_wait_states;
        run_read(0, 32'h300, 3);
        vectors++;
        if (r_hit_cyc !== 9) begin
            miscompares++;
            $display("FAIL wait_hit_cycle: got %0d, want 9", r_hit_cyc);
        end
        vectors++;
        if (r_unstable !== 0) begin
            miscompares++;
            $display("FAIL wait_iaddr_stable: %0d violations, want 0", r_unstable);
        end
        vectors++;
        if (r_n !== 2 || r_addr[0] !== 32'h300 || r_addr[1] !== 32'h304) begin
            miscompares++;
            $display("FAIL wait_fill_addrs: n=%0d a0=%h a1=%h, want 2 300 304", r_n, r_addr[0], r_addr[1]);
        end
    endtask

    task automatic test_flush_abort;
        cur = 0;
        @(negedge clk);
        drive_req(0, 1'b1, 32'h300, 1'b1);
        #1;
        vectors++;
        if (o_ihit !== 1'b0) begin
            miscompares++;
            $display("FAIL flush_blocks_hit: ihit=%b, want 0", o_ihit);
        end
        @(negedge clk);
        drive_req(0, 1'b1, 32'h100, 1'b0);
        @(negedge clk);
        drive_req(0, 1'b0, 32'h500, 1'b0);
        #1;
        vectors++;
        if (o_iren !== 1'b1 || o_iaddr !== 32'h100) begin
            miscompares++;
            $display("FAIL flush_fill_word0: iREN=%b iaddr=%h, want 1 100", o_iren, o_iaddr);
        end
        @(negedge clk);
        drive_req(0, 1'b0, 32'h500, 1'b1);
        #1;
        vectors++;
        if (o_iren !== 1'b1 || o_iaddr !== 32'h104 || o_ihit !== 1'b0) begin
            miscompares++;
            $display("FAIL flush_fill_word1: iREN=%b iaddr=%h ihit=%b, want 1 104 0", o_iren, o_iaddr, o_ihit);
        end
        @(negedge clk);
        drive_req(0, 1'b0, 32'h500, 1'b0);
        #1;
        vectors++;
        if (o_iren !== 1'b0 || o_iaddr !== 32'h0) begin
            miscompares++;
            $display("FAIL flush_to_idle: iREN=%b iaddr=%h, want 0 0", o_iren, o_iaddr);
        end
        run_read(0, 32'h100, 0);
        vectors++;
        if (r_hit_cyc !== 3 || r_addr[0] !== 32'h100 || r_data !== 32'hC0DE0100) begin
            miscompares++;
            $display("FAIL flush_refill: cyc=%0d a0=%h data=%h, want 3 100 c0de0100", r_hit_cyc, r_addr[0], r_data);
        end
        run_read(0, 32'h300, 0);
        vectors++;
        if (r_hit_cyc !== 3) begin
            miscompares++;
            $display("FAIL flush_cleared_300: cyc=%0d, want 3", r_hit_cyc);
        end
    endtask

    task automatic test_conflict;
        cur = 1;
        @(negedge clk);
        rst2 = 1'b1;
        repeat (2) @(negedge clk);
        rst2 = 1'b0;
        run_read(1, 32'h0, 0);
        vectors++;
        if (r_hit_cyc !== 5 || r_data !== 32'hC0DE0000) begin
            miscompares++;
            $display("FAIL conflict_first: cyc=%0d data=%h, want 5 c0de0000", r_hit_cyc, r_data);
        end
        run_read(1, 32'h40, 0);
        vectors++;
        if (r_hit_cyc !== 5 || r_n !== 4) begin
            miscompares++;
            $display("FAIL conflict_miss: cyc=%0d words=%0d, want 5 4", r_hit_cyc, r_n);
        end
        vectors++;
        if (r_addr[0] !== 32'h40 || r_addr[1] !== 32'h44 || r_addr[2] !== 32'h48 || r_addr[3] !== 32'h4C) begin
            miscompares++;
            $display("FAIL conflict_addrs: %h %h %h %h, want 40 44 48 4c", r_addr[0], r_addr[1], r_addr[2], r_addr[3]);
        end
        run_read(1, 32'h0, 0);
        vectors++;
        if (r_hit_cyc !== 5) begin
            miscompares++;
            $display("FAIL conflict_reread: cyc=%0d, want 5", r_hit_cyc);
        end
    endtask

    initial begin
        rst = 1'b1; rst2 = 1'b1; iwait_v = 1'b0; cur = 0;
        drive_req(0, 1'b0, 32'h0, 1'b0);
        drive_req(1, 1'b0, 32'h0, 1'b0);
        test_reset;
        test_cold_miss;
        test_idle_quiet;
        test_hit;
        test_eviction;
        test_wait_states;
        test_flush_abort;
        test_conflict;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
